// File: rtl/vram_arb_pkg.sv
// Shared constants and the RAM-access source tag for the VGA frame-buffer arbiter.
package vram_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;
   localparam int TAG_STAGES = 2;

   typedef enum logic [1:0] {
      SRC_NONE    = 2'd0,
      SRC_VID     = 2'd1,
      SRC_WR      = 2'd2,
      SRC_HOST_RD = 2'd3
   } src_e;

endpackage

// File: rtl/vram_wbuf.sv
// Posted-write FIFO of {addr, data}; head is visible combinationally so the
// arbiter can drain it in the same cycle it is granted.
module vram_wbuf
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level
);

   logic [ADDR_W+DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push_ok;
   logic             pop_ok;

   assign full  = (level_q == LVL_W'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;

   assign head_addr = mem[rd_ptr_q][ADDR_W+DATA_W-1:DATA_W];
   assign head_data = mem[rd_ptr_q][DATA_W-1:0];

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the level unchanged.
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= {push_addr, push_data};
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video fetch always wins, posted host writes
// drain in idle cycles, host reads go last and only with an empty write buffer.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int WBUF_DEPTH = 4,
   localparam int LVL_W     = $clog2(WBUF_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_valid,
   output logic [DATA_W-1:0] vid_data,
   input  logic              host_valid,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ready,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic [LVL_W-1:0]  wbuf_level,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic              wb_push;
   logic              wb_pop;
   logic              wb_full;
   logic              wb_empty;
   logic [ADDR_W-1:0] wb_head_addr;
   logic [DATA_W-1:0] wb_head_data;

   logic host_wr_ok;
   logic host_rd_ok;
   src_e grant_src;

   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

   src_e tag_q [TAG_STAGES];
   src_e tag_d [TAG_STAGES];

   logic              vid_valid_q, vid_valid_d;
   logic [DATA_W-1:0] vid_data_q, vid_data_d;
   logic              host_rvalid_q, host_rvalid_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

   vram_wbuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (WBUF_DEPTH)
   ) u_wbuf (
      .clk       (clk),
      .rst       (rst),
      .push      (wb_push),
      .push_addr (host_addr),
      .push_data (host_wdata),
      .pop       (wb_pop),
      .head_addr (wb_head_addr),
      .head_data (wb_head_data),
      .full      (wb_full),
      .empty     (wb_empty),
      .level     (wbuf_level)
   );

   // A read needs an empty buffer so it can never overtake a posted write.
   always_comb begin
      host_wr_ok = host_valid && host_we && !wb_full && !rst;
      host_rd_ok = host_valid && !host_we && wb_empty && !vid_req && !rst;
      host_ready = host_wr_ok || host_rd_ok;
      wb_push    = host_wr_ok;
      wb_pop     = !vid_req && !wb_empty;

      if (vid_req) begin
         grant_src = SRC_VID;
      end else if (wb_pop) begin
         grant_src = SRC_WR;
      end else if (host_rd_ok) begin
         grant_src = SRC_HOST_RD;
      end else begin
         grant_src = SRC_NONE;
      end
   end

   always_comb begin
      ram_en_d    = (grant_src != SRC_NONE);
      ram_we_d    = (grant_src == SRC_WR);
      ram_addr_d  = '0;
      ram_wdata_d = '0;
      case (grant_src)
         SRC_VID:     ram_addr_d = vid_addr;
         SRC_WR: begin
            ram_addr_d  = wb_head_addr;
            ram_wdata_d = wb_head_data;
         end
         SRC_HOST_RD: ram_addr_d = host_addr;
         default:     ram_addr_d = '0;
      endcase
   end

   // Stage 0 tracks the cycle the RAM sees the access, stage 1 the cycle
   // its read data appears on ram_rdata.
   always_comb begin
      tag_d[0] = grant_src;
      for (int i = 1; i < TAG_STAGES; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   always_comb begin
      vid_valid_d   = (tag_q[TAG_STAGES-1] == SRC_VID);
      host_rvalid_d = (tag_q[TAG_STAGES-1] == SRC_HOST_RD);
      vid_data_d    = vid_valid_d ? ram_rdata : vid_data_q;
      host_rdata_d  = host_rvalid_d ? ram_rdata : host_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_en_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         vid_valid_q   <= 1'b0;
         vid_data_q    <= '0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
         for (int i = 0; i < TAG_STAGES; i++) begin
            tag_q[i] <= SRC_NONE;
         end
      end else begin
         ram_en_q      <= ram_en_d;
         ram_we_q      <= ram_we_d;
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
         vid_valid_q   <= vid_valid_d;
         vid_data_q    <= vid_data_d;
         host_rvalid_q <= host_rvalid_d;
         host_rdata_q  <= host_rdata_d;
         for (int i = 0; i < TAG_STAGES; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign ram_en      = ram_en_q;
   assign ram_we      = ram_we_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign vid_valid   = vid_valid_q;
   assign vid_data    = vid_data_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port RAM and a
// video-fetch scoreboard running alongside the directed sequences.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        vid_req;
   logic [15:0] vid_addr;
   logic        vid_valid;
   logic [7:0]  vid_data;
   logic        host_valid;
   logic        host_we;
   logic [15:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_ready;
   logic        host_rvalid;
   logic [7:0]  host_rdata;
   logic [2:0]  wbuf_level;
   logic        ram_en;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int peak = 0;
   bit rd_expect = 1'b0;

   logic [7:0]  tb_mem     [0:65535];
   bit          tb_written [0:65535];
   logic [23:0] wlog [$];
   int          vq_due [$];
   logic [7:0]  vq_dat [$];

   always #5 clk = ~clk;

   vram_arbiter #(
      .ADDR_W     (16),
      .DATA_W     (8),
      .WBUF_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vid_req     (vid_req),
      .vid_addr    (vid_addr),
      .vid_valid   (vid_valid),
      .vid_data    (vid_data),
      .host_valid  (host_valid),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_ready  (host_ready),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .wbuf_level  (wbuf_level),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   function automatic logic [7:0] init_val(input logic [15:0] a);
      case (a)
         16'h0050: return 8'hA5;
         16'h0400: return 8'hC3;
         16'h0500, 16'h0501, 16'h0502: return 8'hEE;
         default:  return a[7:0] ^ 8'h3C;
      endcase
   endfunction

   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      return tb_written[a] ? tb_mem[a] : init_val(a);
   endfunction

   // Synchronous single-port RAM: read data one cycle after the ram_en cycle.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            tb_mem[ram_addr]     <= ram_wdata;
            tb_written[ram_addr] <= 1'b1;
            wlog.push_back({ram_addr, ram_wdata});
         end else begin
            ram_rdata <= mem_rd(ram_addr);
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %-20s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end else begin
         $display("ok   %-20s value=%0h (cycle %0d)", tag, got, cyc);
      end
   endtask

   // Every video request must come back exactly three cycles later.
   always @(negedge clk) begin
      if (int'(wbuf_level) > peak) peak = int'(wbuf_level);
      if (vq_due.size() > 0 && vq_due[0] == cyc) begin
         check("vid_valid_sb", vid_valid, 1);
         check("vid_data_sb", vid_data, vq_dat[0]);
         void'(vq_due.pop_front());
         void'(vq_dat.pop_front());
      end else if (vid_valid) begin
         check("vid_valid_unexp", vid_valid, 0);
      end
      if (host_rvalid && !rd_expect) check("host_rvalid_unexp", host_rvalid, 0);
      if (rst) begin
         vq_due.delete();
         vq_dat.delete();
      end else if (vid_req) begin
         vq_due.push_back(cyc + 3);
         vq_dat.push_back(mem_rd(vid_addr));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [15:0] a, input logic [7:0] d, input string tag);
      logic acc;
      acc = 1'b0;
      host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      for (int i = 0; i < 40; i++) begin
         #1;
         acc = host_ready;
         step();
         if (acc) break;
      end
      host_valid = 1'b0; host_we = 1'b0;
      check(tag, acc, 1);
   endtask

   task automatic host_read(input logic [15:0] a, input logic [7:0] exp, input string tag,
                            output int acc_cyc, output logic first_ready, output logic [2:0] lvl);
      logic acc, got;
      int   rcyc;
      acc = 1'b0; got = 1'b0; rcyc = 0; acc_cyc = 0; first_ready = 1'b0; lvl = '0;
      host_valid = 1'b1; host_we = 1'b0; host_addr = a; rd_expect = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (i == 0) first_ready = host_ready;
         if (host_ready) begin
            acc = 1'b1; acc_cyc = cyc; lvl = wbuf_level;
         end
         step();
         if (acc) break;
      end
      host_valid = 1'b0;
      check({tag, "_accept"}, acc, 1);
      for (int i = 0; i < 8; i++) begin
         if (host_rvalid) begin
            got = 1'b1; rcyc = cyc;
            break;
         end
         step();
      end
      check({tag, "_rvalid"}, got, 1);
      check({tag, "_latency"}, rcyc - acc_cyc, 3);
      check({tag, "_rdata"}, host_rdata, exp);
      step();
      rd_expect = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 60; i++) begin
         if (wbuf_level == 0) break;
         step();
      end
      check(tag, wbuf_level, 0);
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base, k, accepts, acc_cyc, st, cnt;
      logic        first_ready;
      logic [2:0]  lvl;

      rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
      host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 8'h55;

      // Reset state
      step(); step();
      check("rst_host_ready", host_ready, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_wbuf_level", wbuf_level, 0);
      check("rst_vid_valid", vid_valid, 0);
      rst = 1'b0; host_valid = 1'b0; host_we = 1'b0;
      step(); step();

      // Single video fetch
      vid_req = 1'b1; vid_addr = 16'h0050;
      step();
      vid_req = 1'b0;
      check("t1_valid_n1", vid_valid, 0);
      step();
      check("t1_valid_n2", vid_valid, 0);
      step();
      check("t1_valid_n3", vid_valid, 1);
      check("t1_data", vid_data, 8'hA5);
      check("t1_host_rvalid", host_rvalid, 0);
      step();
      check("t1_pulse_end", vid_valid, 0);
      step(); step();

      // Four writes interleaved with video fetches every other cycle
      base = wlog.size();
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               vid_req  = (i % 2 == 0);
               vid_addr = 16'h0080 + 16'(i);
               step();
            end
            vid_req = 1'b0;
         end
         begin
            host_write(16'h0100, 8'h11, "t2_wr0");
            host_write(16'h0101, 8'h22, "t2_wr1");
            host_write(16'h0102, 8'h33, "t2_wr2");
            host_write(16'h0103, 8'h44, "t2_wr3");
         end
      join
      wait_drain("t2_drain");
      check("t2_peak_le4", peak <= 4, 1);
      check("t2_wcount", wlog.size() - base, 4);
      for (int i = 0; i < 4 && base + i < wlog.size(); i++) begin
         check($sformatf("t2_order%0d", i), wlog[base+i], {16'h0100 + 16'(i), 8'(8'h11 * (i + 1))});
      end
      check("t2_mem103", mem_rd(16'h0103), 8'h44);

      // Full buffer while video holds the port for 10 cycles
      k = 0; accepts = 0;
      vid_req = 1'b1;
      for (int c = 0; c < 10; c++) begin
         vid_addr = 16'h0060 + 16'(c);
         if (k < 6) begin
            host_valid = 1'b1; host_we = 1'b1;
            host_addr = 16'h0300 + 16'(k); host_wdata = 8'h90 + 8'(k);
         end
         #1;
         if (host_ready) begin
            k++; accepts++;
         end
         step();
      end
      check("t3_accepts", accepts, 4);
      check("t3_level_full", wbuf_level, 4);
      vid_req = 1'b0;
      #1;
      check("t3_ready_full", host_ready, 0);
      step();
      check("t3_drain_resume", wbuf_level, 3);
      for (int c = 0; c < 40 && k < 6; c++) begin
         host_valid = 1'b1; host_we = 1'b1;
         host_addr = 16'h0300 + 16'(k); host_wdata = 8'h90 + 8'(k);
         #1;
         if (host_ready) k++;
         step();
      end
      host_valid = 1'b0; host_we = 1'b0;
      check("t3_all_accepted", k, 6);
      wait_drain("t3_drain");
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t3_mem%0d", i), mem_rd(16'h0300 + 16'(i)), 8'h90 + 8'(i));
      end

      // Read-after-write ordering
      host_write(16'h0200, 8'h7E, "t4_wr");
      host_read(16'h0200, 8'h7E, "t4_rd", acc_cyc, first_ready, lvl);
      check("t4_blocked_first", first_ready, 0);
      check("t4_level_at_acc", lvl, 0);
      step();

      // Collision: host read and video fetch in the same cycle
      st = cyc;
      fork
         begin
            vid_req = 1'b1; vid_addr = 16'h0070;
            step();
            vid_req = 1'b0;
         end
         host_read(16'h0400, 8'hC3, "t5_rd", acc_cyc, first_ready, lvl);
      join
      check("t5_first_ready", first_ready, 0);
      check("t5_acc_cycle", acc_cyc - st, 1);
      step();

      // Reset with a host read in flight
      host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0400;
      #1;
      check("t6a_rd_ready", host_ready, 1);
      step();
      host_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t6a_no_rvalid%0d", i), host_rvalid, 0);
         step();
      end

      // Reset with three buffered writes and video fetches in flight
      base = wlog.size();
      vid_req = 1'b1; vid_addr = 16'h00A0;
      host_write(16'h0500, 8'h01, "t6b_wr0");
      host_write(16'h0501, 8'h02, "t6b_wr1");
      host_write(16'h0502, 8'h03, "t6b_wr2");
      check("t6b_level3", wbuf_level, 3);
      check("t6b_vid_data_pre", vid_data, 8'hA0 ^ 8'h3C);
      rst = 1'b1;
      host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0503; host_wdata = 8'h04;
      #1;
      check("t6b_rst_ready", host_ready, 0);
      step();
      check("t6b_ram_en", ram_en, 0);
      check("t6b_ram_we", ram_we, 0);
      check("t6b_ram_addr", ram_addr, 0);
      check("t6b_ram_wdata", ram_wdata, 0);
      check("t6b_vid_valid", vid_valid, 0);
      check("t6b_vid_data", vid_data, 0);
      check("t6b_host_rvalid", host_rvalid, 0);
      check("t6b_host_rdata", host_rdata, 0);
      check("t6b_wbuf_level", wbuf_level, 0);
      rst = 1'b0; vid_req = 1'b0; host_valid = 1'b0; host_we = 1'b0;
      for (int i = 0; i < 10; i++) step();
      cnt = 0;
      for (int i = base; i < wlog.size(); i++) begin
         if (wlog[i][23:16] == 8'h05) cnt++;
      end
      check("t6b_no_writes", cnt, 0);
      check("t6b_mem500", mem_rd(16'h0500), 8'hEE);
      check("t6b_mem502", mem_rd(16'h0502), 8'hEE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
